// File: rtl/carrier_sense_multi.sv
// carrier_sense_multi: per-port CRS/COL generation with CRS hold-off
// stretching and saturating per-port carrier-event counters.
module carrier_sense_multi #(
    parameter int N_PORTS     = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                     CLOCK,
    input  logic                     mr_main_reset,
    input  logic                     repeater_mode,
    input  logic [N_PORTS-1:0]       receiving,
    input  logic [N_PORTS-1:0]       transmitting,
    input  logic                     clear_counts,
    output logic [N_PORTS-1:0]       CRS,
    output logic [N_PORTS-1:0]       COL,
    output logic                     crs_any,
    output logic [N_PORTS*CNT_W-1:0] event_count
);

    localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [HW-1:0] HOLD_LOAD =
        (HOLD_CYCLES > 0) ? HW'(HOLD_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CARRIER = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t             state    [N_PORTS];
    logic [HW-1:0]      hold_cnt [N_PORTS];
    logic [CNT_W-1:0]   cnt      [N_PORTS];
    logic [N_PORTS-1:0] active;

    // own transmission only counts as carrier outside repeater mode
    assign active = receiving | ({N_PORTS{~repeater_mode}} & transmitting);

    // per-port carrier FSM; CRS is a registered output of the FSM
    always_ff @(posedge CLOCK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            CRS <= '0;
            for (int i = 0; i < N_PORTS; i++) begin
                state[i]    <= IDLE;
                hold_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_PORTS; i++) begin
                unique case (state[i])
                    IDLE: begin
                        if (active[i]) begin
                            state[i] <= CARRIER;
                            CRS[i]   <= 1'b1;
                        end
                    end
                    CARRIER: begin
                        if (!active[i]) begin
                            if (HOLD_CYCLES == 0) begin
                                state[i] <= IDLE;
                                CRS[i]   <= 1'b0;
                            end else begin
                                state[i]    <= HOLD;
                                hold_cnt[i] <= HOLD_LOAD;
                            end
                        end
                    end
                    HOLD: begin
                        if (active[i]) begin
                            state[i] <= CARRIER;
                        end else if (hold_cnt[i] == '0) begin
                            state[i] <= IDLE;
                            CRS[i]   <= 1'b0;
                        end else begin
                            hold_cnt[i] <= hold_cnt[i] - HW'(1);
                        end
                    end
                    default: begin
                        state[i] <= IDLE;
                        CRS[i]   <= 1'b0;
                    end
                endcase
            end
        end
    end

    // event counters: count fresh carriers only, saturate, clear wins
    always_ff @(posedge CLOCK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            for (int i = 0; i < N_PORTS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (clear_counts) begin
                    cnt[i] <= '0;
                end else if (state[i] == IDLE && active[i]
                             && cnt[i] != CNT_MAX) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // collision is a plain registered AND, never stretched
    always_ff @(posedge CLOCK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            COL <= '0;
        end else begin
            COL <= {N_PORTS{~repeater_mode}} & receiving & transmitting;
        end
    end

    assign crs_any = |CRS;

    for (genvar g = 0; g < N_PORTS; g++) begin : g_pack
        assign event_count[g*CNT_W +: CNT_W] = cnt[g];
    end

endmodule

// File: tb/tb_carrier_sense_multi.sv
// tb_carrier_sense_multi: two instances (hold-off 2 / no hold-off with
// 2-bit counters) checked against a window-based reference model.
module tb_carrier_sense_multi;

    logic        CLOCK;
    logic        mr_main_reset;
    logic        repeater_mode;
    logic [3:0]  receiving;
    logic [3:0]  transmitting;
    logic        clear_counts;

    logic [3:0]  crs_a, col_a, crs_b, col_b;
    logic        any_a, any_b;
    logic [31:0] ev_a;
    logic [7:0]  ev_b;

    int n_vec = 0;
    int n_err = 0;

    // model: edges since last active edge, and event counts
    int since [2][4];
    int cnt   [2][4];
    int hp    [2];
    int cmax  [2];
    logic [3:0] col_m;

    carrier_sense_multi #(.N_PORTS(4), .HOLD_CYCLES(2), .CNT_W(8)) dut_a (
        .CLOCK(CLOCK), .mr_main_reset(mr_main_reset),
        .repeater_mode(repeater_mode), .receiving(receiving),
        .transmitting(transmitting), .clear_counts(clear_counts),
        .CRS(crs_a), .COL(col_a), .crs_any(any_a), .event_count(ev_a)
    );

    carrier_sense_multi #(.N_PORTS(4), .HOLD_CYCLES(0), .CNT_W(2)) dut_b (
        .CLOCK(CLOCK), .mr_main_reset(mr_main_reset),
        .repeater_mode(repeater_mode), .receiving(receiving),
        .transmitting(transmitting), .clear_counts(clear_counts),
        .CRS(crs_b), .COL(col_b), .crs_any(any_b), .event_count(ev_b)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) begin
                since[k][i] = 1000;
                cnt[k][i]   = 0;
            end
        col_m = '0;
    endtask

    // CRS after an edge = any active edge within the last HOLD+1 edges
    task automatic model_edge();
        logic act;
        logic ev;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) begin
                act = receiving[i] | (!repeater_mode & transmitting[i]);
                ev  = act && (since[k][i] > hp[k]);
                since[k][i] = act ? 0 :
                              (since[k][i] >= 1000 ? 1000 : since[k][i] + 1);
                if (clear_counts)
                    cnt[k][i] = 0;
                else if (ev && cnt[k][i] < cmax[k])
                    cnt[k][i] = cnt[k][i] + 1;
            end
        col_m = {4{~repeater_mode}} & receiving & transmitting;
    endtask

    task automatic check_all();
        logic [3:0]  ec_a, ec_b;
        logic [31:0] ee_a;
        logic [7:0]  ee_b;
        for (int i = 0; i < 4; i++) begin
            ec_a[i] = (since[0][i] <= hp[0]);
            ec_b[i] = (since[1][i] <= hp[1]);
            ee_a[i*8 +: 8] = 8'(cnt[0][i]);
            ee_b[i*2 +: 2] = 2'(cnt[1][i]);
        end
        check("crs_a", 32'(crs_a), 32'(ec_a));
        check("col_a", 32'(col_a), 32'(col_m));
        check("any_a", 32'(any_a), 32'(|ec_a));
        check("cnt_a", ev_a, ee_a);
        check("crs_b", 32'(crs_b), 32'(ec_b));
        check("col_b", 32'(col_b), 32'(col_m));
        check("any_b", 32'(any_b), 32'(|ec_b));
        check("cnt_b", 32'(ev_b), 32'(ee_b));
    endtask

    // called at a negedge: drive, take one edge, check at next negedge
    task automatic cycle(input logic [3:0] r, input logic [3:0] t,
                         input logic m, input logic c);
        receiving     = r;
        transmitting  = t;
        repeater_mode = m;
        clear_counts  = c;
        @(posedge CLOCK);
        model_edge();
        @(negedge CLOCK);
        check_all();
    endtask

    initial begin
        hp[0] = 2;   hp[1] = 0;
        cmax[0] = 255; cmax[1] = 3;
        mr_main_reset = 1'b0;
        receiving = '0; transmitting = '0;
        repeater_mode = 1'b0; clear_counts = 1'b0;
        model_reset();
        repeat (2) @(negedge CLOCK);
        check_all();
        mr_main_reset = 1'b1;

        // hold-off on port 0: high edges 1..4, CRS low after edge 7
        for (int e = 1; e <= 9; e++) begin
            cycle((e <= 4) ? 4'b0001 : 4'b0000, 4'b0, 1'b0, 1'b0);
            check("holdoff_crs0", 32'(crs_a[0]), 32'(e <= 6));
        end
        check("holdoff_cnt0", 32'(ev_a[7:0]), 32'd1);

        // gap masking on port 1: active at edges 1,2,5,6
        for (int e = 1; e <= 11; e++) begin
            cycle((e == 1 || e == 2 || e == 5 || e == 6) ? 4'b0010 : 4'b0,
                  4'b0, 1'b0, 1'b0);
            check("gap_crs1", 32'(crs_a[1]), 32'(e <= 8));
        end
        check("gap_cnt1", 32'(ev_a[15:8]), 32'd1);

        // repeater / collision on port 2
        repeat (2) cycle(4'b0000, 4'b0100, 1'b0, 1'b0);
        check("rep_crs2", 32'(crs_a[2]), 32'd1);
        check("rep_col2", 32'(col_a[2]), 32'd0);
        cycle(4'b0100, 4'b0100, 1'b0, 1'b0);
        check("rep_col2_on", 32'(col_a[2]), 32'd1);
        cycle(4'b0000, 4'b0100, 1'b1, 1'b0);
        check("rep_col2_off", 32'(col_a[2]), 32'd0);
        check("rep_crs2_hold", 32'(crs_a[2]), 32'd1);
        repeat (2) cycle(4'b0000, 4'b0100, 1'b1, 1'b0);
        check("rep_crs2_drop", 32'(crs_a[2]), 32'd0);

        // saturation and clear on the 2-bit counter instance, port 3
        for (int p = 0; p < 5; p++) begin
            cycle(4'b1000, 4'b0, 1'b0, 1'b0);
            cycle(4'b0000, 4'b0, 1'b0, 1'b0);
        end
        check("sat_cnt3", 32'(ev_b[7:6]), 32'd3);
        cycle(4'b1000, 4'b0, 1'b0, 1'b1);
        check("clr_cnt3", 32'(ev_b[7:6]), 32'd0);
        check("clr_crs3", 32'(crs_b[3]), 32'd1);
        cycle(4'b0000, 4'b0, 1'b0, 1'b0);

        // asynchronous reset mid-carrier
        repeat (5) cycle(4'b1111, 4'b0, 1'b0, 1'b0);
        #2 mr_main_reset = 1'b0;
        #1;
        model_reset();
        check("rst_crs_a", 32'(crs_a), 32'd0);
        check("rst_col_a", 32'(col_a), 32'd0);
        check("rst_cnt_a", ev_a, 32'd0);
        check("rst_crs_b", 32'(crs_b), 32'd0);
        @(negedge CLOCK);
        receiving = '0;
        mr_main_reset = 1'b1;
        repeat (4) cycle(4'b0000, 4'b0, 1'b0, 1'b0);

        // randomized traffic on all ports
        for (int n = 0; n < 1500; n++) begin
            cycle(4'($urandom), 4'($urandom),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 31) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/carrier_sense_multi.md
# carrier_sense_multi

Parametrised, multi-port carrier-sense and collision block for the PCS receive/transmit path. It generates per-port CRS and COL from each port's receiving/transmitting indications and the global repeater_mode. CRS deassertion can be stretched by a programmable hold-off, which masks short carrier dropouts. A saturating counter of carrier events is kept per port. It replaces the single-port carrier sense wherever more than one PCS lane, or carrier-extension masking, is needed.

## Interface
- N_PORTS, 4, number of independent ports (1..16)
- HOLD_CYCLES, 2, extra CLOCK edges CRS stays high after carrier activity ends (0..255; 0 = no stretch)
- CNT_W, 8, width of each per-port carrier-event counter (2..16)

- CLOCK  input  1  single clock; all state updates on rising edge
- mr_main_reset  input  1  asynchronous, active-low reset
- repeater_mode  input  1  global; 1 = own transmission does not raise CRS, and COL is suppressed
- receiving  input  N_PORTS  per-port receive activity (bit i = port i)
- transmitting  input  N_PORTS  per-port transmit activity
- clear_counts  input  1  synchronous clear of all event counters
- CRS  output  N_PORTS  per-port carrier sense, registered
- COL  output  N_PORTS  per-port collision, registered
- crs_any  output  1  OR of all CRS bits
- event_count  output  N_PORTS*CNT_W  packed counters; port i at bits [i*CNT_W +: CNT_W]

## Operation
- Per-port activity term: active[i] = receiving[i] | (!repeater_mode & transmitting[i]). It is evaluated every cycle.
- Per-port FSM states: IDLE, CARRIER, HOLD. Each port also has a hold counter of width max(1, clog2(HOLD_CYCLES+1)).
- IDLE:
  - CRS=0.
  - If active, go to CARRIER, set CRS<=1, and increment the event counter.
- CARRIER:
  - CRS=1.
  - If !active and HOLD_CYCLES==0, go to IDLE and set CRS<=0.
  - If !active and HOLD_CYCLES>0, go to HOLD and load the hold counter with HOLD_CYCLES-1. CRS stays 1.
- HOLD:
  - CRS=1.
  - If active, go to CARRIER. The event counter is not incremented, because a re-acquired carrier is the same event.
  - Else if the hold counter is 0, go to IDLE and set CRS<=0.
  - Else decrement the hold counter.
- COL[i] <= !repeater_mode & receiving[i] & transmitting[i].
  - COL is independent of the FSM and is not stretched by HOLD.
- crs_any = |CRS. It is combinational from registered CRS bits and adds no latency.
- Event counters:
  - Increment only on the IDLE->CARRIER transition.
  - Saturate at 2^CNT_W-1 and never wrap.
- clear_counts:
  - Sets all counters to 0 at the next edge.
  - If it coincides with an IDLE->CARRIER transition, clear wins and the counter reads 0.
  - It does not affect the FSM, CRS or COL.
- A repeater_mode change takes effect on active at the next edge. Example: in repeater mode with only transmitting asserted, the port leaves CARRIER and enters HOLD or IDLE.
- Ports are fully independent apart from the shared repeater_mode and clear_counts.

## Timing
- Reset (mr_main_reset=0, asynchronous):
  - CRS=0, COL=0, crs_any=0, all counters 0, all FSMs in IDLE, hold counters 0.
  - Takes effect immediately, without waiting for CLOCK.
  - Reset asserted mid-carrier or mid-HOLD drops CRS without completing the hold-off.
- Reset release: the first active edge after release is a normal IDLE evaluation.
- Assertion latency: active sampled high at edge k gives CRS=1 after edge k.
- Deassertion latency: active first sampled low at edge k gives CRS=0 after edge k+HOLD_CYCLES.
  - HOLD_CYCLES=0 gives 1-cycle latency, identical to the single-port block.
- A gap in active shorter than or equal to HOLD_CYCLES edges leaves CRS continuously high and adds no event count.
- COL latency: 1 edge in both directions.

## Test plan
- Reset: drive receiving=4'b1111 for 5 cycles, then pull mr_main_reset low between edges. CRS, COL and event_count go to 0 immediately. After release with receiving=0, all outputs stay 0.
- Hold-off (HOLD_CYCLES=2): receiving[0] high at edge 1, low from edge 5.
  - CRS[0] is 1 after edge 1 and 0 after edge 7.
  - event_count[0]=1; crs_any tracks CRS[0].
- Gap masking (HOLD_CYCLES=2): receiving[1] pattern 1,1,0,0,1,1,0 then low.
  - CRS[1] stays high without a gap until 2 edges after the final drop.
  - event_count[1]=1.
- Repeater and collision:
  - repeater_mode=0, transmitting[2]=1, receiving[2]=0 gives CRS[2]=1 and COL[2]=0.
  - Adding receiving[2]=1 gives COL[2]=1 one edge later.
  - Then setting repeater_mode=1 with receiving[2]=0 gives COL[2]=0 after 1 edge and CRS[2]=0 after HOLD_CYCLES further edges.
- Saturation and clear (CNT_W=2, HOLD_CYCLES=0):
  - 5 separated pulses on receiving[3] give event_count[3]=3.
  - Asserting clear_counts on the same edge as a 6th pulse's rising edge gives count 0 with CRS[3]=1.
- HOLD_CYCLES=0 regression: random receiving, transmitting and repeater_mode on all ports. Every CRS bit equals active from the previous edge.
